ecp5_multiboot_seq: RTL and testbench

- Parametrised reboot sequencer for the ECP5 OTA path. It selects one of NUM_SLOTS bitstream images and serially shifts the opcode/address sequence to the internal JTAG port.
- The sequence is write-composition-index (0x70) + 32-bit boot address, then refresh (0x79).
- It replaces the fixed, non-functional single-address trigger with a request/ready handshake, per-slot addresses, hold-off, a TCK divider and error reporting.
- It sits between the OTA control logic and the JTAGG primitive wrapper.

---
 rtl/ecp5_multiboot_seq.sv | 171 +++++++++++++++++
 tb/tb_ecp5_multiboot_seq.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ecp5_multiboot_seq.sv
// Reboot sequencer for ECP5 multiboot: shifts write-composition-index + boot address, then refresh, into JTAGG.
// Optional MULTIBOOT_KEY_EN adds an unlock_key input that must match before a request is accepted.
module ecp5_multiboot_seq #(
    parameter int                      NUM_SLOTS   = 4,
    parameter int                      SLOT_W      = 2,
    parameter logic [NUM_SLOTS*32-1:0] SLOT_ADDRS  = {32'h0030_0000, 32'h0020_0000,
                                                      32'h0010_0000, 32'h0000_0000},
    parameter int                      HOLDOFF_CYC = 1024,
    parameter int                      TCK_DIV     = 4,
    parameter logic [7:0]              CMD_WCOMP   = 8'h70,
    parameter logic [7:0]              CMD_REFRESH = 8'h79
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [SLOT_W-1:0] req_slot,
    output logic              req_ready,
    input  logic              abort,
`ifdef MULTIBOOT_KEY_EN
    input  logic [31:0]       unlock_key,
`endif
    output logic              busy,
    output logic              err,
    output logic              done,
    output logic              jtck,
    output logic              jtdi,
    output logic              jshift,
    output logic              jupdate
);

    localparam int DIV_W  = $clog2(TCK_DIV) + 1;
    localparam int HOLD_W = $clog2(HOLDOFF_CYC + 1) + 1;
    localparam logic [DIV_W-1:0]  HALF_LAST = DIV_W'(TCK_DIV - 1);
    localparam logic [DIV_W-1:0]  UPD_LAST  = DIV_W'(2 * TCK_DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLDOFF_CYC);

    typedef enum logic [2:0] {
        S_IDLE, S_HOLDOFF, S_SHIFT1, S_UPD1, S_SHIFT2, S_UPD2, S_DONE
    } state_t;

    state_t            state;
    logic [39:0]       shift_reg;
    logic [5:0]        bit_cnt;
    logic [DIV_W-1:0]  div_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [31:0]       slot_addr;
    logic              slot_ok;
    logic              key_ok;
    logic              bit_last;

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        slot_addr = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (int'(req_slot) == i) slot_addr = SLOT_ADDRS[32*i +: 32];
        end
    end

    assign slot_ok  = int'(req_slot) < NUM_SLOTS;
`ifdef MULTIBOOT_KEY_EN
    assign key_ok   = (unlock_key == 32'hB007_5AFE);
`else
    assign key_ok   = 1'b1;
`endif
    assign bit_last = (bit_cnt == ((state == S_SHIFT1) ? 6'd39 : 6'd7));

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
            div_cnt   <= '0;
            hold_cnt  <= '0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            err       <= 1'b0;
            done      <= 1'b0;
            jtck      <= 1'b0;
            jtdi      <= 1'b0;
            jshift    <= 1'b0;
            jupdate   <= 1'b0;
        end else begin
            err  <= 1'b0;
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        if (!slot_ok || !key_ok) begin
                            err <= 1'b1;
                        end else begin
                            shift_reg <= {CMD_WCOMP, slot_addr};
                            hold_cnt  <= '0;
                            req_ready <= 1'b0;
                            busy      <= 1'b1;
                            state     <= S_HOLDOFF;
                        end
                    end
                end
                S_HOLDOFF: begin
                    if (abort) begin
                        hold_cnt  <= '0;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end else if (hold_cnt == HOLD_LAST) begin
                        hold_cnt <= '0;
                        div_cnt  <= '0;
                        bit_cnt  <= '0;
                        jtck     <= 1'b0;
                        jshift   <= 1'b1;
                        jtdi     <= shift_reg[39];
                        state    <= S_SHIFT1;
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                S_SHIFT1, S_SHIFT2: begin
                    if (div_cnt == HALF_LAST) begin
                        div_cnt <= '0;
                        if (!jtck) begin
                            jtck <= 1'b1;
                        end else begin
                            // Falling TCK edge: present the next bit, or close the field group.
                            jtck <= 1'b0;
                            if (bit_last) begin
                                bit_cnt <= '0;
                                jshift  <= 1'b0;
                                jtdi    <= 1'b0;
                                jupdate <= 1'b1;
                                state   <= (state == S_SHIFT1) ? S_UPD1 : S_UPD2;
                            end else begin
                                bit_cnt   <= bit_cnt + 6'd1;
                                jtdi      <= shift_reg[38];
                                shift_reg <= {shift_reg[38:0], 1'b0};
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                S_UPD1, S_UPD2: begin
                    if (div_cnt == UPD_LAST) begin
                        div_cnt <= '0;
                        jupdate <= 1'b0;
                        if (state == S_UPD1) begin
                            shift_reg <= {CMD_REFRESH, 32'h0};
                            jtdi      <= CMD_REFRESH[7];
                            jshift    <= 1'b1;
                            state     <= S_SHIFT2;
                        end else begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                S_DONE: begin
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ecp5_multiboot_seq.sv
// Self-checking bench for ecp5_multiboot_seq: two instances (4 slots/slow TCK/holdoff 8, 3 slots/TCK_DIV 1/no holdoff).
// Expected JTAG bit streams are queued when a request is driven and popped on every observed jtck rising edge.
module tb_ecp5_multiboot_seq;

    localparam int HOLD_A = 8;
    localparam int DIV_A  = 2;
    localparam logic [127:0] ADDRS_A = {32'h0030_0000, 32'h0020_0000, 32'h0010_0000, 32'h0000_0000};
    localparam logic [95:0]  ADDRS_B = {32'hCAFE_0000, 32'hAB12_3400, 32'h0000_1234};

    logic [31:0] addr_tab_a [4] = '{32'h0000_0000, 32'h0010_0000, 32'h0020_0000, 32'h0030_0000};
    logic [31:0] addr_tab_b [3] = '{32'h0000_1234, 32'hAB12_3400, 32'hCAFE_0000};

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid_a, abort_a, req_valid_b, abort_b;
    logic [1:0] req_slot_a, req_slot_b;
    logic       a_req_ready, a_busy, a_err, a_done, a_jtck, a_jtdi, a_jshift, a_jupdate;
    logic       b_req_ready, b_busy, b_err, b_done, b_jtck, b_jtdi, b_jshift, b_jupdate;
`ifdef MULTIBOOT_KEY_EN
    logic [31:0] key_a, key_b;
`endif

    always #5 clk = ~clk;

    ecp5_multiboot_seq #(
        .NUM_SLOTS(4), .SLOT_W(2), .SLOT_ADDRS(ADDRS_A), .HOLDOFF_CYC(HOLD_A), .TCK_DIV(DIV_A),
        .CMD_WCOMP(8'h70), .CMD_REFRESH(8'h79)
    ) dut_a (
        .clk(clk), .rst(rst), .req_valid(req_valid_a), .req_slot(req_slot_a), .req_ready(a_req_ready),
        .abort(abort_a),
`ifdef MULTIBOOT_KEY_EN
        .unlock_key(key_a),
`endif
        .busy(a_busy), .err(a_err), .done(a_done), .jtck(a_jtck), .jtdi(a_jtdi),
        .jshift(a_jshift), .jupdate(a_jupdate)
    );

    ecp5_multiboot_seq #(
        .NUM_SLOTS(3), .SLOT_W(2), .SLOT_ADDRS(ADDRS_B), .HOLDOFF_CYC(0), .TCK_DIV(1),
        .CMD_WCOMP(8'h70), .CMD_REFRESH(8'h79)
    ) dut_b (
        .clk(clk), .rst(rst), .req_valid(req_valid_b), .req_slot(req_slot_b), .req_ready(b_req_ready),
        .abort(abort_b),
`ifdef MULTIBOOT_KEY_EN
        .unlock_key(key_b),
`endif
        .busy(b_busy), .err(b_err), .done(b_done), .jtck(b_jtck), .jtdi(b_jtdi),
        .jshift(b_jshift), .jupdate(b_jupdate)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    bit exp_a [$];
    bit exp_b [$];

    int rises_a = 0, done_a = 0, err_cyc_a = 0, busy_cyc_a = 0, jshift_cyc_a = 0, jupd_cyc_a = 0, upd_pulses_a = 0;
    int rises_b = 0, done_b = 0, err_cyc_b = 0, busy_cyc_b = 0, jshift_cyc_b = 0, jupd_cyc_b = 0;
    logic jtck_q_a = 1'b0, jtdi_q_a = 1'b0, jupd_q_a = 1'b0, jtck_q_b = 1'b0;
    bit   exp_bit_a, exp_bit_b;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    always @(posedge clk) cyc++;

    // Monitors sample on the falling clk edge, away from the DUT's active edge.
    always @(negedge clk) begin
        if (a_jtck && !jtck_q_a) begin
            rises_a++;
            check("a_jshift_at_rise", a_jshift, 1'b1);
            check("a_bit_expected", exp_a.size() != 0, 1'b1);
            if (exp_a.size() != 0) begin
                exp_bit_a = exp_a.pop_front();
                check("a_bit", a_jtdi, exp_bit_a);
            end
        end
        if (a_jtck && jtck_q_a) check("a_jtdi_stable_high", a_jtdi, jtdi_q_a);
        if (a_jupdate && !jupd_q_a) upd_pulses_a++;
        done_a       += int'(a_done);
        err_cyc_a    += int'(a_err);
        busy_cyc_a   += int'(a_busy);
        jshift_cyc_a += int'(a_jshift);
        jupd_cyc_a   += int'(a_jupdate);
        jtck_q_a = a_jtck;
        jtdi_q_a = a_jtdi;
        jupd_q_a = a_jupdate;
    end

    always @(negedge clk) begin
        if (b_jtck && !jtck_q_b) begin
            rises_b++;
            check("b_bit_expected", exp_b.size() != 0, 1'b1);
            if (exp_b.size() != 0) begin
                exp_bit_b = exp_b.pop_front();
                check("b_bit", b_jtdi, exp_bit_b);
            end
        end
        done_b       += int'(b_done);
        err_cyc_b    += int'(b_err);
        busy_cyc_b   += int'(b_busy);
        jshift_cyc_b += int'(b_jshift);
        jupd_cyc_b   += int'(b_jupdate);
        jtck_q_b = b_jtck;
    end

    task automatic push_seq(input logic [31:0] addr, input bit to_b);
        logic [39:0] w;
        logic [7:0]  r;
        w = {8'h70, addr};
        r = 8'h79;
        for (int i = 39; i >= 0; i--) if (to_b) exp_b.push_back(w[i]); else exp_a.push_back(w[i]);
        for (int i = 7; i >= 0; i--)  if (to_b) exp_b.push_back(r[i]); else exp_a.push_back(r[i]);
    endtask

    task automatic request_a(input logic [1:0] slot, output int acc);
        @(posedge clk); #1;
        req_valid_a = 1'b1;
        req_slot_a  = slot;
        @(posedge clk); #1;
        req_valid_a = 1'b0;
        @(negedge clk);
        acc = cyc;
    endtask

    task automatic wait_done_a(input string tag);
        int n;
        n = 0;
        while (!a_done && n < 2000) begin @(negedge clk); n++; end
        check(tag, a_done, 1'b1);
    endtask

    task automatic run_full_a(input string tag, input logic [1:0] slot, input bit abort_mid);
        int acc, n, r0, d0, js0, ju0, up0;
        r0 = rises_a; d0 = done_a; js0 = jshift_cyc_a; ju0 = jupd_cyc_a; up0 = upd_pulses_a;
        push_seq(addr_tab_a[slot], 1'b0);
        request_a(slot, acc);
        check({tag, "_busy_ready"}, {a_busy, a_req_ready}, 2'b10);
        n = 0;
        while (!a_jshift && n < 100) begin @(negedge clk); n++; end
        check({tag, "_jshift_delay"}, cyc - acc, HOLD_A + 1);
        if (abort_mid) begin
            repeat (5) @(posedge clk);
            #1 abort_a = 1'b1;
            repeat (3) @(posedge clk);
            #1 abort_a = 1'b0;
        end
        wait_done_a({tag, "_done"});
        @(negedge clk);
        check({tag, "_idle_after"}, {a_busy, a_req_ready, a_done}, 3'b010);
        check({tag, "_rises"}, rises_a - r0, 48);
        check({tag, "_done_count"}, done_a - d0, 1);
        check({tag, "_jshift_cycles"}, jshift_cyc_a - js0, 48 * 2 * DIV_A);
        check({tag, "_jupdate_cycles"}, jupd_cyc_a - ju0, 4 * DIV_A);
        check({tag, "_jupdate_pulses"}, upd_pulses_a - up0, 2);
        check({tag, "_queue_empty"}, exp_a.size(), 0);
    endtask

    initial begin
        int acc, n, r0, d0, e0, b0, js0, ju0;
        rst = 1'b1;
        req_valid_a = 1'b0; req_slot_a = '0; abort_a = 1'b0;
        req_valid_b = 1'b0; req_slot_b = '0; abort_b = 1'b0;
`ifdef MULTIBOOT_KEY_EN
        key_a = 32'hB007_5AFE;
        key_b = 32'hB007_5AFE;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outs_a", {a_req_ready, a_busy, a_err, a_done, a_jtck, a_jtdi, a_jshift, a_jupdate}, 8'b1000_0000);
        check("reset_outs_b", {b_req_ready, b_busy, b_err, b_done, b_jtck, b_jtdi, b_jshift, b_jupdate}, 8'b1000_0000);
        @(posedge clk); #1 rst = 1'b0;

        // Slot 1: 0x70_0010_0000 then 0x79.
        run_full_a("main_slot1", 2'd1, 1'b0);

        // Reset in the middle of the first field group, coinciding with a new request.
        r0 = rises_a; d0 = done_a;
        push_seq(addr_tab_a[2], 1'b0);
        request_a(2'd2, acc);
        n = 0;
        while ((rises_a - r0) < 17 && n < 500) begin @(negedge clk); n++; end
        check("midshift_reached_bit17", (rises_a - r0) >= 17, 1'b1);
        @(posedge clk); #1;
        rst = 1'b1; req_valid_a = 1'b1; req_slot_a = 2'd0;
        @(posedge clk); #1;
        rst = 1'b0; req_valid_a = 1'b0;
        @(negedge clk);
        check("midshift_reset_outs", {a_req_ready, a_busy, a_err, a_done, a_jtck, a_jtdi, a_jshift, a_jupdate}, 8'b1000_0000);
        exp_a.delete();
        r0 = rises_a;
        repeat (40) @(negedge clk);
        check("midshift_no_done", done_a - d0, 0);
        check("midshift_rst_wins", {a_busy, a_req_ready}, 2'b01);
        check("midshift_no_rises", rises_a - r0, 0);
        run_full_a("after_reset_slot3", 2'd3, 1'b0);

        // Abort during holdoff cycle 4: back to IDLE with no JTAG activity.
        r0 = rises_a; d0 = done_a; js0 = jshift_cyc_a; ju0 = jupd_cyc_a;
        request_a(2'd0, acc);
        repeat (3) @(posedge clk);
        #1 abort_a = 1'b1;
        @(posedge clk);
        #1 abort_a = 1'b0;
        repeat (300) @(negedge clk);
        check("abort_hold_idle", {a_busy, a_req_ready}, 2'b01);
        check("abort_hold_no_rises", rises_a - r0, 0);
        check("abort_hold_no_jshift", jshift_cyc_a - js0, 0);
        check("abort_hold_no_jupdate", jupd_cyc_a - ju0, 0);
        check("abort_hold_no_done", done_a - d0, 0);

        // Abort while shifting is ignored.
        run_full_a("abort_in_shift", 2'd0, 1'b1);

        // req_valid held: exactly one sequence, the next accepted one cycle after done.
        d0 = done_a;
        push_seq(addr_tab_a[2], 1'b0);
        push_seq(addr_tab_a[2], 1'b0);
        @(posedge clk); #1;
        req_valid_a = 1'b1; req_slot_a = 2'd2;
        wait_done_a("held_first_done");
        check("held_one_seq_consumed", exp_a.size(), 48);
        @(negedge clk);
        check("held_idle_gap", {a_busy, a_req_ready}, 2'b01);
        @(negedge clk);
        check("held_second_start", {a_busy, a_req_ready}, 2'b10);
        @(posedge clk); #1 req_valid_a = 1'b0;
        wait_done_a("held_second_done");
        @(negedge clk);
        check("held_done_count", done_a - d0, 2);
        check("held_queue_empty", exp_a.size(), 0);

        // Invalid slot on the 3-slot instance: single err pulse, nothing else.
        e0 = err_cyc_b; b0 = busy_cyc_b; r0 = rises_b;
        @(posedge clk); #1;
        req_valid_b = 1'b1; req_slot_b = 2'd3;
        @(posedge clk); #1;
        req_valid_b = 1'b0;
        repeat (30) @(negedge clk);
        check("b_invalid_err_cycles", err_cyc_b - e0, 1);
        check("b_invalid_no_busy", busy_cyc_b - b0, 0);
        check("b_invalid_no_jtck", rises_b - r0, 0);

        // Valid slot 2 on the 3-slot instance with zero holdoff and TCK_DIV=1.
        r0 = rises_b; d0 = done_b; js0 = jshift_cyc_b; ju0 = jupd_cyc_b;
        push_seq(addr_tab_b[2], 1'b1);
        @(posedge clk); #1;
        req_valid_b = 1'b1; req_slot_b = 2'd2;
        @(posedge clk); #1;
        req_valid_b = 1'b0;
        @(negedge clk);
        acc = cyc;
        n = 0;
        while (!b_jshift && n < 100) begin @(negedge clk); n++; end
        check("b_jshift_delay", cyc - acc, 1);
        n = 0;
        while (!b_done && n < 2000) begin @(negedge clk); n++; end
        check("b_done", b_done, 1'b1);
        @(negedge clk);
        check("b_idle_after", {b_busy, b_req_ready}, 2'b01);
        check("b_rises", rises_b - r0, 48);
        check("b_done_count", done_b - d0, 1);
        check("b_jshift_cycles", jshift_cyc_b - js0, 96);
        check("b_jupdate_cycles", jupd_cyc_b - ju0, 4);
        check("b_queue_empty", exp_b.size(), 0);

`ifdef MULTIBOOT_KEY_EN
        // Wrong key: one err pulse, no activity.
        e0 = err_cyc_a; b0 = busy_cyc_a; r0 = rises_a;
        key_a = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        req_valid_a = 1'b1; req_slot_a = 2'd1;
        @(posedge clk); #1;
        req_valid_a = 1'b0;
        key_a = 32'hB007_5AFE;
        repeat (30) @(negedge clk);
        check("key_bad_err_cycles", err_cyc_a - e0, 1);
        check("key_bad_no_busy", busy_cyc_a - b0, 0);
        check("key_bad_no_jtck", rises_a - r0, 0);
        run_full_a("key_good_slot2", 2'd2, 1'b0);
        // Bad key and invalid slot together still give one err pulse.
        e0 = err_cyc_b;
        key_b = 32'h0;
        @(posedge clk); #1;
        req_valid_b = 1'b1; req_slot_b = 2'd3;
        @(posedge clk); #1;
        req_valid_b = 1'b0;
        repeat (10) @(negedge clk);
        check("key_bad_invalid_slot_err", err_cyc_b - e0, 1);
`endif

        check("final_queue_a_empty", exp_a.size(), 0);
        check("final_queue_b_empty", exp_b.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
